// File: rtl/cache_pkg.sv
// Shared constants, address-field layout and FSM state encoding for the
// direct-mapped cache controller (32 lines x 4 words, 10-bit word address).
package cache_pkg;

    localparam int ADDR_W   = 10;
    localparam int INDEX_W  = 5;
    localparam int OFFSET_W = 2;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

    // Word address split into its cache fields, MSB first
    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] offset;
    } cache_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REFILL = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_WRMEM  = 3'd3,
        ST_RESP   = 3'd4
    } cache_state_t;

endpackage

// File: rtl/cache_tag_array.sv
// Per-line valid bit and tag storage: combinational read port, single
// synchronous write port, whole array cleared asynchronously by rst (active-low).
module cache_tag_array #(
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] i_rd_index,
    output logic               o_rd_valid,
    output logic [TAG_W-1:0]   o_rd_tag,
    input  logic               i_wr_en,
    input  logic [INDEX_W-1:0] i_wr_index,
    input  logic [TAG_W-1:0]   i_wr_tag
);

    localparam int DEPTH = 1 << INDEX_W;

    logic [DEPTH-1:0] r_valid;
    logic [TAG_W-1:0] r_tag [DEPTH];
    logic [DEPTH-1:0] w_line_we;

    // One write-enable per line, decoded from the write index
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_we
            assign w_line_we[gi] = i_wr_en && (i_wr_index == INDEX_W'(gi));
        end
    endgenerate

    // Line update on refill completion; reset invalidates every line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_tag[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_line_we[i]) begin
                    r_valid[i] <= 1'b1;
                    r_tag[i]   <= i_wr_tag;
                end
            end
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through / no-write-allocate cache controller.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
import cache_pkg::*;

module cache_controller #(
    parameter int ADDR_W   = cache_pkg::ADDR_W,
    parameter int INDEX_W  = cache_pkg::INDEX_W,
    parameter int OFFSET_W = cache_pkg::OFFSET_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic [ADDR_W-1:0] cache_addr,
    output logic              write_cache,
    output logic              read_cache,
    output logic              write_from_memory,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    cache_state_t          r_state, r_state_next;
    cache_addr_t           r_addr, r_addr_next;
    logic                  r_we, r_we_next;
    logic [OFFSET_W-1:0]   r_beat, r_beat_next;

    logic [INDEX_W-1:0]    w_cpu_index;
    logic [TAG_W-1:0]      w_cpu_tag;
    logic                  w_line_valid;
    logic [TAG_W-1:0]      w_line_tag;
    logic                  w_hit;
    logic                  w_tag_we;
    logic [ADDR_W-1:0]     w_refill_addr;
    logic                  w_accept;

    assign w_cpu_index   = cpu_addr[OFFSET_W +: INDEX_W];
    assign w_cpu_tag     = cpu_addr[ADDR_W-1 -: TAG_W];
    assign w_hit         = w_line_valid && (w_line_tag == w_cpu_tag);
    assign w_refill_addr = {r_addr.tag, r_addr.index, r_beat};
    // Acceptance is gated by rst so a held request cannot strobe during reset
    assign w_accept      = rst && (r_state == ST_IDLE) && cpu_req;

    cache_tag_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_tags (
        .clk        (clk),
        .rst        (rst),
        .i_rd_index (w_cpu_index),
        .o_rd_valid (w_line_valid),
        .o_rd_tag   (w_line_tag),
        .i_wr_en    (w_tag_we),
        .i_wr_index (r_addr.index),
        .i_wr_tag   (r_addr.tag)
    );

    // State, latched request and refill beat registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_beat  <= '0;
        end else begin
            r_state <= r_state_next;
            r_addr  <= r_addr_next;
            r_we    <= r_we_next;
            r_beat  <= r_beat_next;
        end
    end

    // Next-state and strobe decode; every output forced low while in reset
    always_comb begin
        r_state_next      = r_state;
        r_addr_next       = r_addr;
        r_we_next         = r_we;
        r_beat_next       = r_beat;
        cpu_ready         = 1'b0;
        cache_addr        = r_addr;
        write_cache       = 1'b0;
        read_cache        = 1'b0;
        write_from_memory = 1'b0;
        mem_rd_req        = 1'b0;
        mem_wr_req        = 1'b0;
        mem_addr          = '0;
        w_tag_we          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_req) begin
                    r_addr_next = cpu_addr;
                    r_we_next   = cpu_we;
                    r_beat_next = '0;
                    // The data array must see the incoming address in the acceptance cycle
                    cache_addr  = cpu_addr;
                    if (cpu_we) begin
                        write_cache  = w_hit;
                        r_state_next = ST_WRMEM;
                    end else if (w_hit) begin
                        read_cache   = 1'b1;
                        r_state_next = ST_RESP;
                    end else begin
                        r_state_next = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                mem_rd_req = 1'b1;
                mem_addr   = w_refill_addr;
                if (mem_ack) begin
                    write_from_memory = 1'b1;
                    cache_addr        = w_refill_addr;
                    r_beat_next       = r_beat + 1'b1;
                    if (r_beat == '1) begin
                        w_tag_we     = 1'b1;
                        r_state_next = ST_LOOKUP;
                    end
                end
            end
            ST_LOOKUP: begin
                read_cache   = 1'b1;
                r_state_next = ST_RESP;
            end
            ST_WRMEM: begin
                mem_wr_req = 1'b1;
                mem_addr   = r_addr;
                if (mem_ack) begin
                    r_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                cpu_ready    = 1'b1;
                r_state_next = ST_IDLE;
            end
            default: begin
                r_state_next = ST_IDLE;
            end
        endcase
        if (!rst) begin
            cpu_ready         = 1'b0;
            cache_addr        = '0;
            write_cache       = 1'b0;
            read_cache        = 1'b0;
            write_from_memory = 1'b0;
            mem_rd_req        = 1'b0;
            mem_wr_req        = 1'b0;
            mem_addr          = '0;
            w_tag_we          = 1'b0;
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    // Saturating hit/miss counters, stepped once per accepted request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (w_accept) begin
            if (w_hit) begin
                if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
            end else begin
                if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_accept;
`endif

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameters: ADDR_W, 10, word address width; INDEX_W, 5, line index bits; OFFSET_W, 2, word-in-line bits.
REQ-002 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: cpu_req  in  1  request, held until cpu_ready; cpu_we  in  1  1=write, 0=read; cpu_addr  in  10  word address.
REQ-004 SHALL have port: cpu_ready  out  1  one-cycle completion pulse; read data valid on the cache data_out in this cycle.
REQ-005 SHALL have ports: cache_addr  out  10  address to data array; write_cache, read_cache, write_from_memory  out  1 each  data-array strobes.
REQ-006 SHALL have ports: mem_rd_req, mem_wr_req  out  1  main-memory requests; mem_addr  out  10; mem_ack  in  1  beat/write done; refill data arrives on the data array's memory input during mem_ack.

Function
REQ-007 SHALL decode address as offset=addr[1:0], index=addr[6:2], tag=addr[9:7]; direct-mapped, 32 lines x 4 words.
REQ-008 SHALL keep per-line valid bit and 3-bit tag; hit = valid[index] && tag match.
REQ-009 SHALL implement states IDLE, REFILL, LOOKUP, WRMEM, RESP.
REQ-010 IDLE, cpu_req=1: latch cpu_addr/cpu_we; read hit -> read_cache=1 same cycle, go RESP; read miss -> REFILL, beat=0; write -> go WRMEM, and write_cache=1 same cycle if hit.
REQ-011 REFILL: mem_rd_req=1, mem_addr={tag,index,beat}; on mem_ack assert write_from_memory=1 with cache_addr=mem_addr in that cycle, beat+1; after beat 3 acked set valid/tag, go LOOKUP.
REQ-012 LOOKUP: read_cache=1 at latched address, go RESP.
REQ-013 WRMEM: mem_wr_req=1, mem_addr=latched address (write-through, no-write-allocate); on mem_ack go RESP.
REQ-014 RESP: cpu_ready=1 for exactly one cycle, go IDLE; a new request is accepted no earlier than the next IDLE cycle.
REQ-015 Read-hit latency: cpu_ready exactly 1 cycle after acceptance; read miss: 1 cycle after the 4th mem_ack + 1 (LOOKUP).
REQ-016 SHALL never assert more than one of write_cache, read_cache, write_from_memory in a cycle; never mem_rd_req and mem_wr_req together.
REQ-017 cache_addr SHALL equal latched address except during REFILL beats; mem_* SHALL be 0 outside REFILL/WRMEM.
REQ-018 Write miss SHALL leave valid/tag and data array unchanged.
REQ-019 mem_ack outside REFILL/WRMEM SHALL be ignored; beat counter wraps only via state exit.

Reset
REQ-020 On rst=0: state IDLE, all valid bits 0, tags 0, beat 0, all outputs 0, latched address 0.
REQ-021 Reset mid-REFILL SHALL abort; the line stays invalid; no outstanding request after release.

Configuration
REQ-022 With CACHE_STATS_EN defined: outputs hit_count, miss_count (16 bits each), incremented at acceptance of hit/miss (reads and writes), saturating at 16'hFFFF, cleared by reset.
REQ-023 Without CACHE_STATS_EN: those ports and counters SHALL not exist; other behaviour identical.

Structure
REQ-024 Shared package cache_pkg SHALL hold ADDR_W/INDEX_W/OFFSET_W/TAG_W constants, address-field typedef and FSM state enum.
REQ-025 Tag/valid storage SHALL be sub-module cache_tag_array (32 x {valid, tag}, async read, sync write, async clear on rst).

Verification
REQ-026 After reset, read 10'h084 -> 4 mem_rd_req beats at 0x084..0x087, 4 write_from_memory pulses, LOOKUP read_cache, cpu_ready; miss_count=1.
REQ-027 Repeat read 10'h085 -> no mem_rd_req, read_cache in acceptance cycle, cpu_ready next cycle; hit_count=1.
REQ-028 Read 10'h104 (same index 1, tag 2) -> refill evicts; subsequent read 10'h084 misses again.
REQ-029 Write 10'h086 while line valid -> write_cache same cycle plus mem_wr_req to 0x086 until mem_ack; write 10'h3F0 with line invalid -> mem_wr_req only, no write_cache.
REQ-030 Assert rst after 2nd refill ack -> all outputs 0; then read 10'h084 -> full 4-beat refill (line invalid).
REQ-031 Spurious mem_ack in IDLE -> no strobe, no state change; strobe mutual exclusion checked by assertion throughout.
